mem_ctrl: RTL

Memory-side slave for the core's external bus: it accepts the single `mem_valid`/`mem_ready` request stream produced by the core's arbiter and serves it from on-chip word RAM or a memory-mapped UART transmitter. Reads and writes are decoded by address, wait states are inserted, byte strobes are applied, and unmapped accesses are flagged. It sits directly downstream of the core, which halts while `mem_valid & !mem_ready`.

---
 rtl/mem_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: bus slave serving the core's mem_valid/mem_ready stream from on-chip word RAM
// and an optional memory-mapped 8N1 UART transmitter with an 8-entry TX FIFO.
// Optional feature macro: MEM_CTRL_UART_EN (UART, TX FIFO, UART_DATA/UART_STAT registers).
// Without it the UART addresses are unmapped and uart_tx is tied high.
module mem_ctrl #(
    parameter int unsigned RAM_WORDS = 4096,
    parameter int unsigned WAIT      = 1,
    parameter int unsigned CLK_DIV   = 434,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_rdata,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        uart_tx,
    output logic        bus_err
);

    localparam int unsigned AW = $clog2(RAM_WORDS);

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("mem_ctrl: CLK_DIV must be at least 2");
    end
    if (WAIT > 15) begin : g_bad_wait
        $error("mem_ctrl: WAIT must be in 0..15");
    end

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        ready_q, err_q;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] ram [RAM_WORDS];

    // In IDLE the request is decoded straight off the bus so WAIT=0 can respond next cycle.
    logic [31:0]   cur_addr;
    logic [3:0]    cur_wstrb;
    logic [AW-1:0] ram_idx;
    logic          ram_hit, uart_hit, stat_hit_u, stall, mapped;
    logic [2:0]    stat_bits;
    logic          unused_addr_bits;

    assign cur_addr         = (state_q == StIdle) ? mem_addr : addr_q;
    assign cur_wstrb        = (state_q == StIdle) ? mem_wstrb : wstrb_q;
    assign ram_idx          = cur_addr[AW+1:2];
    assign ram_hit          = (cur_addr[31:AW+2] == '0);
    assign mapped           = ram_hit | uart_hit;
    assign unused_addr_bits = ^cur_addr[1:0];

`ifdef MEM_CTRL_UART_EN
    logic             data_hit, stat_hit;
    logic [7:0]       fifo_mem [8];
    logic [2:0]       wptr_q, rptr_q;
    logic [3:0]       count_q;
    logic             fifo_full, fifo_empty, push, pop;
    localparam int unsigned DW = $clog2(CLK_DIV);
    logic             tx_busy_q, tx_lead_q, tx_q;
    logic [8:0]       shift_q;
    logic [3:0]       bit_q;
    logic [DW-1:0]    div_q;

    assign data_hit   = (cur_addr[31:2] == 30'h2000_0000);
    assign stat_hit   = (cur_addr[31:2] == 30'h2000_0001);
    assign uart_hit   = data_hit | stat_hit;
    assign stat_hit_u = stat_hit;
    assign fifo_full  = (count_q == 4'd8);
    assign fifo_empty = (count_q == 4'd0);
    assign stall      = data_hit & cur_wstrb[0] & fifo_full;
    assign stat_bits  = {tx_busy_q, fifo_empty, fifo_full};
    assign push       = (state_q == StResp) & data_hit & cur_wstrb[0];
    assign pop        = ~tx_busy_q & ~fifo_empty;
    assign uart_tx    = tx_q;

    // FIFO pointers and occupancy; a simultaneous push and pop cancel in the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 3'd1;
            if (pop)  rptr_q <= rptr_q + 3'd1;
            count_q <= count_q + {3'b0, push} - {3'b0, pop};
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr_q] <= wdata_q[7:0];
    end

    // Transmitter: one lead cycle after the pop, then start, d0..d7, stop, each CLK_DIV clocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_busy_q <= 1'b0;
            tx_lead_q <= 1'b0;
            tx_q      <= 1'b1;
            shift_q   <= '1;
            bit_q     <= '0;
            div_q     <= '0;
        end else if (pop) begin
            tx_busy_q <= 1'b1;
            tx_lead_q <= 1'b1;
            shift_q   <= {1'b1, fifo_mem[rptr_q]};
        end else if (tx_lead_q) begin
            tx_lead_q <= 1'b0;
            tx_q      <= 1'b0;
            bit_q     <= '0;
            div_q     <= '0;
        end else if (tx_busy_q) begin
            if (div_q == DW'(CLK_DIV - 1)) begin
                div_q <= '0;
                if (bit_q == 4'd9) begin
                    tx_busy_q <= 1'b0;
                    tx_q      <= 1'b1;
                end else begin
                    tx_q    <= shift_q[0];
                    shift_q <= {1'b1, shift_q[8:1]};
                    bit_q   <= bit_q + 4'd1;
                end
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end
`else
    assign uart_hit   = 1'b0;
    assign stat_hit_u = 1'b0;
    assign stall      = 1'b0;
    assign stat_bits  = '0;
    assign uart_tx    = 1'b1;
`endif

    // Next-state: count down the wait states, hold on a push into a full FIFO.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (mem_valid) begin
                    cnt_d   = 4'(WAIT);
                    state_d = (WAIT == 0 && !stall) ? StResp : StWait;
                end
            end
            StWait: begin
                if (cnt_q > 4'd1) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (!stall) begin
                    cnt_d   = 4'd0;
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Read mux; unmapped addresses and UART_DATA read as zero.
    always_comb begin
        rdata_d = '0;
        if (ram_hit) begin
            rdata_d = ram[ram_idx];
        end else if (stat_hit_u) begin
            rdata_d = {29'b0, stat_bits};
        end
    end

    // Control state and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == StResp);
            rdata_q <= (state_d == StResp) ? rdata_d : '0;
            if (state_q == StResp && !mapped) err_q <= 1'b1;
        end
    end

    // Request capture at acceptance.
    always_ff @(posedge clk) begin
        if (state_q == StIdle && mem_valid) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
        end
    end

    // RAM byte-lane writes commit in RESP; reset in that cycle drops the write.
    always_ff @(posedge clk) begin
        if (!rst && state_q == StResp && ram_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_wstrb[b]) ram[ram_idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign bus_err   = err_q;

endmodule
